disk_track_cache: RTL and testbench

DISK_TRACK_CACHE -- requirements
Module: disk_track_cache

---
 rtl/disk_pkg.sv | 21 ++
 rtl/disk_track_cache_if.sv | 32 +++
 rtl/sd_sector_seq.sv | 75 +++++++
 rtl/disk_track_cache.sv | 203 ++++++++++++++++++++
 tb/tb_disk_track_cache.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/disk_pkg.sv
// Shared types and constants for the disk track cache.
//   state_e            : controller states (IDLE, WRITE, READ)
//   SECS_PER_TRACK_DEF : default 512-byte sectors per track
//   drv_w()            : width of a drive index, never below one bit
package disk_pkg;

    localparam int unsigned SECS_PER_TRACK_DEF = 13;
    localparam int unsigned LBA_W              = 32;
    localparam int unsigned SEC_W              = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    function automatic int unsigned drv_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disk_track_cache_if.sv
// Bus between the track cache and its host / HPS side.
//   master : drives track, img_mounted, img_present, dirty_set, sd_ack
//   slave  : drives sd_rd, sd_wr, sd_lba, buf_drive, buf_sec, cpu_wait
interface disk_track_cache_if import disk_pkg::*; #(
    parameter int unsigned NUM_DRIVES = 2,
    parameter int unsigned TRACK_BITS = 6
);
    localparam int unsigned DRV_W = drv_w(NUM_DRIVES);

    logic [NUM_DRIVES*TRACK_BITS-1:0] track;
    logic [NUM_DRIVES-1:0]            img_mounted;
    logic [NUM_DRIVES-1:0]            img_present;
    logic [NUM_DRIVES-1:0]            dirty_set;
    logic [NUM_DRIVES-1:0]            sd_ack;
    logic [NUM_DRIVES-1:0]            sd_rd;
    logic [NUM_DRIVES-1:0]            sd_wr;
    logic [LBA_W-1:0]                 sd_lba;
    logic [DRV_W-1:0]                 buf_drive;
    logic [SEC_W-1:0]                 buf_sec;
    logic                             cpu_wait;

    modport master (
        output track, img_mounted, img_present, dirty_set, sd_ack,
        input  sd_rd, sd_wr, sd_lba, buf_drive, buf_sec, cpu_wait
    );

    modport slave (
        input  track, img_mounted, img_present, dirty_set, sd_ack,
        output sd_rd, sd_wr, sd_lba, buf_drive, buf_sec, cpu_wait
    );

endinterface

// File: rtl/sd_sector_seq.sv
// Sector sequencer shared by track read and write-back.
// Ports: clk_sys/reset; load_i starts a track (masks + base LBA);
// ack_i is the selected drive's acknowledge; rd_o/wr_o are the
// per-drive requests; lba_o/sec_o the current address/sector;
// done_c pulses on the final acknowledge falling edge.
module sd_sector_seq import disk_pkg::*; #(
    parameter int unsigned NUM_DRIVES     = 2,
    parameter int unsigned SECS_PER_TRACK = SECS_PER_TRACK_DEF
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [NUM_DRIVES-1:0] rd_mask_i,
    input  logic [NUM_DRIVES-1:0] wr_mask_i,
    input  logic [LBA_W-1:0]      lba_base_i,
    input  logic                  ack_i,
    output logic [NUM_DRIVES-1:0] rd_o,
    output logic [NUM_DRIVES-1:0] wr_o,
    output logic [LBA_W-1:0]      lba_o,
    output logic [SEC_W-1:0]      sec_o,
    output logic                  done_c
);
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECS_PER_TRACK - 1);

    logic [NUM_DRIVES-1:0] rd_q, wr_q;
    logic [LBA_W-1:0]      lba_q;
    logic [SEC_W-1:0]      sec_q;
    logic                  ack_q, busy_q;
    logic                  ack_rise, ack_fall;

    assign ack_rise = busy_q &  ack_i & ~ack_q;
    assign ack_fall = busy_q & ~ack_i &  ack_q;
    // Track is finished once the request was already dropped on the last sector.
    assign done_c   = ack_fall & ~|(rd_q | wr_q);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            lba_q  <= '0;
            sec_q  <= '0;
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
        end else if (load_i) begin
            // Forget the previous drive's ack level so no stale edge is seen.
            rd_q   <= rd_mask_i;
            wr_q   <= wr_mask_i;
            lba_q  <= lba_base_i;
            sec_q  <= '0;
            ack_q  <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            ack_q <= ack_i;
            if (ack_rise) begin
                lba_q <= lba_q + LBA_W'(1);
                if (sec_q == LAST_SEC) begin
                    rd_q <= '0;
                    wr_q <= '0;
                end
            end
            if (ack_fall) begin
                sec_q <= sec_q + SEC_W'(1);
                if (done_c) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign rd_o  = rd_q;
    assign wr_o  = wr_q;
    assign lba_o = lba_q;
    assign sec_o = sec_q;

endmodule

// File: rtl/disk_track_cache.sv
// Per-drive track cache controller: reloads a drive's track buffer from SD
// whenever its requested track changes or its image is (re)mounted, stalling
// the CPU for the whole transfer.
// Ports: clk_sys, reset (async, active high); bus (slave modport) carries
// track/mount/present/dirty/ack inputs and SD request/address/buffer outputs.
// Optional: define DISK_TRACK_CACHE_WRITEBACK_EN to write a dirty track back
// before loading the new one.
module disk_track_cache import disk_pkg::*; #(
    parameter int unsigned NUM_DRIVES     = 2,
    parameter int unsigned SECS_PER_TRACK = SECS_PER_TRACK_DEF,
    parameter int unsigned TRACK_BITS     = 6
) (
    input  logic              clk_sys,
    input  logic              reset,
    disk_track_cache_if.slave bus
);
    localparam int unsigned DRV_W = drv_w(NUM_DRIVES);

    state_e                state_q;
    logic [DRV_W-1:0]      drive_q;
    logic [TRACK_BITS-1:0] target_q;
    logic                  cpu_wait_q;
    logic [TRACK_BITS-1:0] cur_track_q [NUM_DRIVES];
    logic [NUM_DRIVES-1:0] reload_q, mounted_q, present_q;
`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
    logic [NUM_DRIVES-1:0] dirty_q;
`endif

    logic [TRACK_BITS-1:0] trk [NUM_DRIVES];
    logic [NUM_DRIVES-1:0] pending, sel_onehot, drv_onehot, rd_mask, wr_mask;
    logic [DRV_W-1:0]      sel_idx;
    logic                  sel_valid, load, done_c;
    logic [LBA_W-1:0]      lba_base;
    logic [NUM_DRIVES-1:0] seq_wr;

    function automatic logic [LBA_W-1:0] lba_of(input logic [TRACK_BITS-1:0] t);
        return LBA_W'(SECS_PER_TRACK) * LBA_W'(t);
    endfunction

    // Unpack per-drive track numbers.
    always_comb begin
        for (int d = 0; d < NUM_DRIVES; d++) begin
            trk[d] = bus.track[d*TRACK_BITS +: TRACK_BITS];
        end
    end

    // Pending drives, lowest index wins (scan downwards so it is written last).
    always_comb begin
        pending   = '0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int d = NUM_DRIVES - 1; d >= 0; d--) begin
            pending[d] = bus.img_present[d] & ((cur_track_q[d] != trk[d]) | reload_q[d]);
            if (pending[d]) begin
                sel_valid = 1'b1;
                sel_idx   = DRV_W'(d);
            end
        end
        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;
        drv_onehot          = '0;
        drv_onehot[drive_q] = 1'b1;
    end

    // Sequencer start requests: new selection, or write-back -> read hand-over.
    always_comb begin
        load     = 1'b0;
        rd_mask  = '0;
        wr_mask  = '0;
        lba_base = '0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    load = 1'b1;
`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
                    if (dirty_q[sel_idx]) begin
                        wr_mask  = sel_onehot;
                        lba_base = lba_of(cur_track_q[sel_idx]);
                    end else
`endif
                    begin
                        rd_mask  = sel_onehot;
                        lba_base = lba_of(trk[sel_idx]);
                    end
                end
            end
`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
            WRITE: begin
                if (done_c) begin
                    load     = 1'b1;
                    rd_mask  = drv_onehot;
                    lba_base = lba_of(target_q);
                end
            end
`endif
            default: ;
        endcase
    end

    sd_sector_seq #(
        .NUM_DRIVES    (NUM_DRIVES),
        .SECS_PER_TRACK(SECS_PER_TRACK)
    ) u_seq (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .load_i    (load),
        .rd_mask_i (rd_mask),
        .wr_mask_i (wr_mask),
        .lba_base_i(lba_base),
        .ack_i     (bus.sd_ack[drive_q]),
        .rd_o      (bus.sd_rd),
        .wr_o      (seq_wr),
        .lba_o     (bus.sd_lba),
        .sec_o     (bus.buf_sec),
        .done_c    (done_c)
    );

    // Controller state, per-drive bookkeeping and registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            drive_q    <= '0;
            target_q   <= '0;
            cpu_wait_q <= 1'b0;
            reload_q   <= '1;
            mounted_q  <= '0;
            present_q  <= '0;
            for (int d = 0; d < NUM_DRIVES; d++) begin
                cur_track_q[d] <= '0;
            end
`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
            dirty_q    <= '0;
`endif
        end else begin
            mounted_q <= bus.img_mounted;
            present_q <= bus.img_present;
`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
            // The drive being transferred cannot be re-dirtied until it is back in IDLE.
            for (int d = 0; d < NUM_DRIVES; d++) begin
                if (bus.dirty_set[d] && !(state_q != IDLE && drive_q == DRV_W'(d))) begin
                    dirty_q[d] <= 1'b1;
                end
            end
`endif
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        drive_q           <= sel_idx;
                        target_q          <= trk[sel_idx];
                        cpu_wait_q        <= 1'b1;
                        reload_q[sel_idx] <= 1'b0;
                        state_q           <= READ;
`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
                        if (dirty_q[sel_idx]) begin
                            state_q <= WRITE;
                        end
`endif
                    end
                end
`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
                WRITE: begin
                    if (done_c) begin
                        dirty_q[drive_q] <= 1'b0;
                        state_q          <= READ;
                    end
                end
`endif
                READ: begin
                    if (done_c) begin
                        cur_track_q[drive_q] <= target_q;
                        cpu_wait_q           <= 1'b0;
                        state_q              <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            for (int d = 0; d < NUM_DRIVES; d++) begin
                // Image removed: adopt the requested track, nothing to flush.
                if (present_q[d] && !bus.img_present[d]) begin
                    cur_track_q[d] <= trk[d];
`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
                    dirty_q[d]     <= 1'b0;
`endif
                end
                // Mount end schedules a reload; placed last so it survives a same-cycle selection.
                if (mounted_q[d] && !bus.img_mounted[d]) begin
                    reload_q[d] <= 1'b1;
                end
            end
        end
    end

`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
    assign bus.sd_wr = seq_wr;
`else
    logic unused_bits;
    assign unused_bits = ^{seq_wr, bus.dirty_set};
    assign bus.sd_wr   = '0;
`endif
    assign bus.buf_drive = drive_q;
    assign bus.cpu_wait  = cpu_wait_q;

endmodule

// File: tb/tb_disk_track_cache.sv
// Directed bench for disk_track_cache (2 drives, 13 sectors/track, 6-bit tracks).
// The write-back scenario runs only when DISK_TRACK_CACHE_WRITEBACK_EN is defined.
module tb_disk_track_cache;

    localparam int unsigned ND  = 2;
    localparam int unsigned SPT = 13;
    localparam int unsigned TB  = 6;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #5 clk_sys = ~clk_sys;

    disk_track_cache_if #(.NUM_DRIVES(ND), .TRACK_BITS(TB)) bus ();

    disk_track_cache #(
        .NUM_DRIVES    (ND),
        .SECS_PER_TRACK(SPT),
        .TRACK_BITS    (TB)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_track(input int d, input logic [TB-1:0] t);
        bus.track[d*TB +: TB] = t;
    endtask

    task automatic wait_req();
        for (int n = 0; n < 20; n++) begin
            if ((bus.sd_rd | bus.sd_wr) != '0) break;
            tick();
        end
        chk("req_seen", 32'((bus.sd_rd | bus.sd_wr) != '0), 32'd1);
    endtask

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            chk("idle_req", 32'(bus.sd_rd | bus.sd_wr), 32'd0);
            chk("idle_wait", 32'(bus.cpu_wait), 32'd0);
            tick();
        end
    endtask

    // HPS model: acknowledge sectors first..first+count-1 of drive d.
    task automatic serve(input int d, input logic [31:0] base, input bit wr,
                         input int first, input int count);
        logic [ND-1:0] mask, rd_exp, wr_exp;
        mask    = '0;
        mask[d] = 1'b1;
        rd_exp  = wr ? '0 : mask;
        wr_exp  = wr ? mask : '0;
        wait_req();
        for (int i = first; i < first + count; i++) begin
            chk("sd_rd", 32'(bus.sd_rd), 32'(rd_exp));
            chk("sd_wr", 32'(bus.sd_wr), 32'(wr_exp));
            chk("sd_lba", bus.sd_lba, base + 32'(i));
            chk("buf_sec", 32'(bus.buf_sec), 32'(i));
            chk("buf_drive", 32'(bus.buf_drive), 32'(d));
            chk("cpu_wait", 32'(bus.cpu_wait), 32'd1);
            bus.sd_ack[d] = 1'b1;
            tick();
            tick();
            if (i == int'(SPT) - 1) chk("req_drop", 32'(bus.sd_rd | bus.sd_wr), 32'd0);
            else                    chk("req_hold", 32'(bus.sd_rd | bus.sd_wr), 32'(mask));
            bus.sd_ack[d] = 1'b0;
            tick();
        end
        if (first + count == int'(SPT)) begin
            chk("lba_end", bus.sd_lba, base + 32'(SPT));
            chk("wait_end", 32'(bus.cpu_wait), wr ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        bus.track       = '0;
        bus.img_mounted = '0;
        bus.img_present = '0;
        bus.dirty_set   = '0;
        bus.sd_ack      = '0;

        // Reset values
        #2;
        chk("rst_rd", 32'(bus.sd_rd), 32'd0);
        chk("rst_wr", 32'(bus.sd_wr), 32'd0);
        chk("rst_lba", bus.sd_lba, 32'd0);
        chk("rst_drive", 32'(bus.buf_drive), 32'd0);
        chk("rst_sec", 32'(bus.buf_sec), 32'd0);
        chk("rst_wait", 32'(bus.cpu_wait), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        idle_check(2);

        // Drive 0 present on track 0: full reload from LBA 0
        set_track(0, 6'd0);
        set_track(1, 6'd5);
        bus.img_present = 2'b01;
        wait_req();
        // Ack from the unselected drive must be ignored
        bus.sd_ack[1] = 1'b1;
        tick();
        tick();
        bus.sd_ack[1] = 1'b0;
        tick();
        tick();
        chk("foreign_ack_lba", bus.sd_lba, 32'd0);
        chk("foreign_ack_sec", 32'(bus.buf_sec), 32'd0);
        serve(0, 32'd0, 1'b0, 0, 13);
        idle_check(3);

        // Drive 1 appears on track 7: reload at 7*13 = 91
        set_track(1, 6'd7);
        bus.img_present = 2'b11;
        serve(1, 32'd91, 1'b0, 0, 13);
        idle_check(2);

        // Drive 0 to track 17 (221); drive 1 changes to 5 mid-transfer, served after
        set_track(0, 6'd17);
        serve(0, 32'd221, 1'b0, 0, 4);
        set_track(1, 6'd5);
        serve(0, 32'd221, 1'b0, 4, 9);
        chk("cur_track0", 32'(dut.cur_track_q[0]), 32'd17);
        serve(1, 32'd65, 1'b0, 0, 13);
        idle_check(2);

        // Remount drive 1 with unchanged track 5: reload at 65
        bus.img_mounted[1] = 1'b1;
        tick();
        tick();
        bus.img_mounted[1] = 1'b0;
        serve(1, 32'd65, 1'b0, 0, 13);
        idle_check(2);

`ifdef DISK_TRACK_CACHE_WRITEBACK_EN
        // Dirty drive 0 moves 17 -> 18: write back 221.., then read 234..
        bus.dirty_set[0] = 1'b1;
        tick();
        bus.dirty_set[0] = 1'b0;
        tick();
        set_track(0, 6'd18);
        wait_req();
        bus.dirty_set[0] = 1'b1;
        tick();
        bus.dirty_set[0] = 1'b0;
        serve(0, 32'd221, 1'b1, 0, 13);
        serve(0, 32'd234, 1'b0, 0, 13);
        idle_check(4);
`endif

        // Image removal adopts the requested track without SD access
        set_track(1, 6'd9);
        bus.img_present = 2'b01;
        tick();
        tick();
        bus.img_present = 2'b11;
        tick();
        idle_check(4);

        // Reset during sector 6 of a reload: requests drop at once, then full reloads
        set_track(0, 6'd20);
        serve(0, 32'd260, 1'b0, 0, 6);
        reset = 1'b1;
        #1;
        chk("mid_rst_rd", 32'(bus.sd_rd), 32'd0);
        chk("mid_rst_wait", 32'(bus.cpu_wait), 32'd0);
        chk("mid_rst_lba", bus.sd_lba, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        serve(0, 32'd260, 1'b0, 0, 13);
        serve(1, 32'd117, 1'b0, 0, 13);
        idle_check(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
